// File: rtl/pipe_ctrl.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | pipe_ctrl: pipeline hazard, flush and memory-wait controller               |
// | Rev 1.0                                                                    |
// +---------------------------------------------------------------------------+
module pipe_ctrl #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rt,
  input  logic        ex_memread,
  input  logic        ex_regw,
  input  logic [4:0]  ex_rd,
  input  logic        branch_taken,
  input  logic        dm_req,
  input  logic        dm_ready,
  output logic        pc_wr,
  output logic        if_id_wr,
  output logic        if_id_flush,
  output logic        id_ex_wr,
  output logic        id_ex_flush,
  output logic        ex_mem_wr,
  output logic        mem_wb_wr,
  output logic        mem_err,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
);

  localparam int CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

  localparam logic [1:0] S_INIT  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_MWAIT = 2'd2;
  localparam logic [1:0] S_ERR   = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] wait_q, wait_d;
  logic [15:0]   stall_q, stall_d;
  logic [15:0]   flush_q, flush_d;
  logic          active;
  logic          load_use;

  assign load_use = ex_memread && ex_regw && (ex_rd != 5'd0) &&
                    ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));

  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    stall_d     = stall_q;
    flush_d     = flush_q;
    active      = 1'b0;
    pc_wr       = 1'b0;
    if_id_wr    = 1'b0;
    if_id_flush = 1'b0;
    id_ex_wr    = 1'b0;
    id_ex_flush = 1'b0;
    ex_mem_wr   = 1'b0;
    mem_wb_wr   = 1'b0;

    case (state_q)
      S_INIT: state_d = S_RUN;
      S_RUN: begin
        if (dm_req && !dm_ready) begin
          state_d = S_MWAIT;
          wait_d  = '0;
        end else begin
          active = 1'b1;
        end
      end
      S_MWAIT: begin
        // A ready arriving on the timeout cycle still completes the access
        if (!dm_ready) begin
          wait_d = wait_q + 1'b1;
          if (wait_d == CW'(TIMEOUT)) state_d = S_ERR;
        end else begin
          active  = 1'b1;
          state_d = S_RUN;
        end
      end
      default: state_d = S_ERR;
    endcase

    if (active) begin
      pc_wr     = 1'b1;
      if_id_wr  = 1'b1;
      id_ex_wr  = 1'b1;
      ex_mem_wr = 1'b1;
      mem_wb_wr = 1'b1;
      if (branch_taken) begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
        if (flush_q != 16'hFFFF) flush_d = flush_q + 16'd1;
      end else if (load_use) begin
        pc_wr       = 1'b0;
        if_id_wr    = 1'b0;
        id_ex_flush = 1'b1;
      end
    end

    if (((state_q == S_RUN) || (state_q == S_MWAIT)) && !pc_wr &&
        (stall_q != 16'hFFFF))
      stall_d = stall_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_INIT;
      wait_q  <= '0;
      stall_q <= 16'd0;
      flush_q <= 16'd0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign mem_err   = (state_q == S_ERR);
  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;

endmodule
`default_nettype wire

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 The block SHALL have these ports, one per line: name, direction, width, meaning.
- clk  in  1  clock; reset rst, asynchronous, active-high.
- rst  in  1  reset; clock clk.
- id_rs  in  5  rs field of instruction in ID.
- id_rt  in  5  rt field of instruction in ID.
- id_uses_rt  in  1  ID instruction reads rt.
- ex_memread  in  1  EX instruction is a load (ID/EX MEM2R).
- ex_regw  in  1  EX instruction writes a register.
- ex_rd  in  5  EX destination register.
- branch_taken  in  1  branch/jump resolved taken in EX.
- dm_req  in  1  MEM stage is accessing data memory this cycle.
- dm_ready  in  1  data memory completes the access this cycle.
- pc_wr  out  1  PC write enable.
- if_id_wr  out  1  IF/ID write enable.
- if_id_flush  out  1  IF/ID load bubble.
- id_ex_wr  out  1  ID/EX write enable.
- id_ex_flush  out  1  ID/EX load bubble (control bits cleared).
- ex_mem_wr  out  1  EX/MEM write enable.
- mem_wb_wr  out  1  MEM/WB write enable.
- mem_err  out  1  sticky data-memory timeout flag.
- stall_cnt  out  16  saturating count of PC-stall cycles.
- flush_cnt  out  16  saturating count of branch flushes.
REQ-002 Parameter: TIMEOUT, default 255, max MWAIT cycles before error.

Function
REQ-003 FSM states SHALL be INIT, RUN, MWAIT, ERR; state register clocked on posedge clk.
REQ-004 INIT: all *_wr and flushes 0; next state RUN unconditionally (one cycle).
REQ-005 ERR: all *_wr 0, flushes 0, mem_err 1; no exit except rst.
REQ-006 RUN, priority 1, memory wait = dm_req && !dm_ready: all five *_wr 0, flushes 0; next state MWAIT.
REQ-007 MWAIT: while !dm_ready freeze as REQ-006, wait counter +1 per cycle; on dm_ready evaluate REQ-008..010 in that cycle and go to RUN.
REQ-008 Priority 2, branch_taken: all *_wr 1, if_id_flush 1, id_ex_flush 1; branch overrides load-use.
REQ-009 Priority 3, load-use = ex_memread && ex_regw && ex_rd!=0 && (ex_rd==id_rs || (id_uses_rt && ex_rd==id_rt)): pc_wr 0, if_id_wr 0, id_ex_flush 1, id_ex_wr/ex_mem_wr/mem_wb_wr 1.
REQ-010 Otherwise all *_wr 1, flushes 0.
REQ-011 Control outputs SHALL be combinational from state and inputs (zero-cycle latency).
REQ-012 Wait counter (8-bit min) SHALL clear on entry to MWAIT; when it reaches TIMEOUT with dm_ready still 0, next state ERR.
REQ-013 dm_ready on the TIMEOUT cycle SHALL win: go to RUN, no error.
REQ-014 stall_cnt SHALL increment each cycle in RUN/MWAIT with pc_wr 0; saturate at 0xFFFF.
REQ-015 flush_cnt SHALL increment each cycle REQ-008 applies; saturate at 0xFFFF.
REQ-016 Freeze, branch and load-use in the same cycle: freeze only; flush_cnt unchanged, stall_cnt +1.

Reset
REQ-017 rst SHALL asynchronously force state INIT, wait counter 0, stall_cnt 0, flush_cnt 0, mem_err 0.
REQ-018 While rst high, all *_wr and flush outputs SHALL be 0; rst mid-MWAIT or in ERR SHALL return to INIT.

Verification
REQ-019 Release rst -> cycle 1 all *_wr 0 (INIT); cycle 2 all *_wr 1, counters 0.
REQ-020 ex_memread=1, ex_regw=1, ex_rd=5, id_rs=5 one cycle -> pc_wr=0, if_id_wr=0, id_ex_flush=1, stall_cnt=1; ex_rd=0 same inputs -> no stall.
REQ-021 Load-use plus branch_taken same cycle -> all *_wr 1, both flushes 1, flush_cnt +1, stall_cnt unchanged.
REQ-022 dm_req=1, dm_ready=0 for 3 cycles then dm_ready=1 -> 3 frozen cycles, stall_cnt=3, 4th cycle normal, state RUN.
REQ-023 dm_req=1, dm_ready never -> after TIMEOUT+1 frozen cycles mem_err=1 and persists; assert rst -> mem_err=0, INIT.
REQ-024 Force 65540 load-use stalls -> stall_cnt holds 0xFFFF.
